// File: rtl/sm_fx_divider_pkg.sv
// Shared fixed-point definitions for the sign-magnitude divider:
// default word format, magnitude constants and the control-state encoding.
package sm_fx_divider_pkg;

  localparam int FX_W    = 24;
  localparam int FX_FRAC = 14;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } div_state_t;

  function automatic int fx_iters(input int w, input int frac);
    return w - 1 + frac;
  endfunction

  // +1.0 expressed as a magnitude with 'frac' fractional bits.
  function automatic logic [63:0] fx_one_mag(input int frac);
    return 64'(1) << frac;
  endfunction

  // All-ones magnitude for a 'w'-bit sign-magnitude word.
  function automatic logic [63:0] fx_max_mag(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift in the next dividend bit, compare
// against the divisor magnitude and conditionally subtract.
module sm_div_step
  import sm_fx_divider_pkg::*;
#(
  parameter int W = FX_W
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-2:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  logic [W-1:0] shifted;

  // A set guard bit means the shifted value exceeds any divisor, so the
  // subtraction is taken and the modular W-bit difference is still exact.
  always_comb begin
    shifted  = {rem[W-2:0], din};
    qbit     = rem[W-1] || (shifted >= {1'b0, divisor});
    rem_next = qbit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/sm_fx_divider.sv
// Multi-cycle sign-magnitude fixed-point divider Q = R / S (or 1 / S),
// with optional round-half-up and divide-by-zero / overflow saturation.
module sm_fx_divider
  import sm_fx_divider_pkg::*;
#(
  parameter int W     = FX_W,
  parameter int FRAC  = FX_FRAC,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] R_in,
  input  logic [W-1:0] S_in,
  input  logic         recip_mode,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         dz,
  output logic         ovf
);

  localparam int N  = fx_iters(W, FRAC);
  localparam int CW = $clog2(N + 1);
  localparam logic [W-2:0] ONE    = (W-1)'(fx_one_mag(FRAC));
  localparam logic [W-2:0] MAXMAG = (W-1)'(fx_max_mag(W));

  div_state_t    state, next_state;
  logic          sign_q, rsign_q, dz_sel_q;
  logic [W-2:0]  smag_q;
  logic [N-1:0]  dvd_q, quo_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  r_eff;
  logic [W-1:0]  step_rem;
  logic          step_bit;
  logic          round_up;
  logic [N:0]    quo_rnd;
  logic [W-2:0]  fin_mag;
  logic          fin_sign, fin_ovf;

  assign r_eff = recip_mode ? {1'b0, ONE} : R_in;

  sm_div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .din      (dvd_q[N-1]),
    .divisor  (smag_q),
    .rem_next (step_rem),
    .qbit     (step_bit)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (S_in[W-2:0] == '0) ? FIN : ITER;
      ITER: if (cnt_q == CW'(1)) next_state = FIN;
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Final quotient shaping; the extra quotient bit catches a rounding carry.
  always_comb begin
    round_up = (ROUND != 0) && ({rem_q, 1'b0} >= {2'b00, smag_q});
    quo_rnd  = {1'b0, quo_q} + (N+1)'(round_up);
    fin_ovf  = 1'b0;
    fin_mag  = quo_rnd[W-2:0];
    fin_sign = sign_q;
    if (dz_sel_q) begin
      fin_mag  = MAXMAG;
      fin_sign = rsign_q;
    end else if (quo_rnd > (N+1)'(MAXMAG)) begin
      fin_mag = MAXMAG;
      fin_ovf = 1'b1;
    end
    if (fin_mag == '0) fin_sign = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      dz_sel_q <= 1'b0;
      smag_q   <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= r_eff[W-1] ^ S_in[W-1];
            rsign_q  <= r_eff[W-1];
            smag_q   <= S_in[W-2:0];
            dz_sel_q <= (S_in[W-2:0] == '0);
            dvd_q    <= N'(r_eff[W-2:0]) << FRAC;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= CW'(N);
            busy     <= 1'b1;
          end
        end
        ITER: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[N-2:0], step_bit};
          dvd_q <= {dvd_q[N-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        FIN: begin
          result <= {fin_sign, fin_mag};
          dz     <= dz_sel_q;
          ovf    <= fin_ovf;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
